// File: rtl/noc_pkg.sv
// Shared NoC packet layout, type codes and the
// sum/threshold node state encoding.
package noc_pkg;

  localparam int SRC_HI  = 34;
  localparam int SRC_LO  = 31;
  localparam int DST_HI  = 30;
  localparam int DST_LO  = 27;
  localparam int TYPE_HI = 26;
  localparam int TYPE_LO = 24;
  localparam int TS_HI   = 23;
  localparam int TS_LO   = 16;
  localparam int ROW_HI  = 15;
  localparam int ROW_LO  = 8;
  localparam int PSUM_HI = 7;
  localparam int PSUM_LO = 0;

  localparam logic [2:0] TYPE_FILTER = 3'b000;
  localparam logic [2:0] TYPE_IFMAP  = 3'b001;
  localparam logic [2:0] TYPE_PSUM   = 3'b010;
  localparam logic [2:0] TYPE_SPIKE  = 3'b011;

  typedef enum logic [1:0] {
    ST_ACC,
    ST_FIRE,
    ST_SEND
  } st_state_e;

endpackage

// File: rtl/st_membrane_mem.sv
// Per-row membrane potential store: one write
// port, combinational read.
module st_membrane_mem #(
  parameter int DEPTH = 3,
  parameter int ACC_W = 12,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [ACC_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [ACC_W-1:0] rdata_o
);

  logic [ACC_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sum_threshold_node.sv
// Accumulates NUM_PE psums per output row, adds the
// residual potential and emits one spike packet.
module sum_threshold_node
  import noc_pkg::*;
#(
  parameter int           WIDTH    = 35,
  parameter logic [3:0]   ST_ADDR  = 4'b0011,
  parameter logic [3:0]   OUT_ADDR = 4'b1111,
  parameter int           NUM_PE   = 3,
  parameter int           DEPTH    = 3,
  parameter int           NUM_TS   = 10,
  parameter int           ACC_W    = 12,
  parameter int           THRESH   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             done,
  output logic             err
);

  localparam int PC_W  = $clog2(NUM_PE + 1);
  localparam int ROW_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  st_state_e        state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [PC_W-1:0]  pcnt_q, pcnt_d;
  logic [7:0]       row_q, row_d;
  logic [7:0]       ts_q, ts_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             accept, pkt_ok, take;
  logic             last_psum, out_hs;
  logic             last_row, last_ts;
  logic [ACC_W-1:0] psum_ext, mem_rd;
  logic [ACC_W-1:0] res, pot, mem_wd;
  logic             spike, mem_we;
  logic             unused_bits;

  function automatic logic [ACC_W-1:0] sat_add(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b
  );
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  assign unused_bits = ^{in_data[SRC_HI:SRC_LO],
                         in_data[TS_HI:ROW_LO]};

  assign pkt_ok = (in_data[DST_HI:DST_LO] == ST_ADDR)
               && (in_data[TYPE_HI:TYPE_LO] == TYPE_PSUM);
  assign accept    = in_valid && in_ready;
  assign take      = accept && pkt_ok;
  assign last_psum = take
                  && (pcnt_q == PC_W'(NUM_PE - 1));
  assign out_hs    = out_valid && out_ready;
  assign last_row  = (row_q == 8'(DEPTH - 1));
  assign last_ts   = (ts_q == 8'(NUM_TS - 1));
  assign psum_ext  = ACC_W'(in_data[PSUM_HI:PSUM_LO]);

  // ts==0 masks stale residuals from the previous run
  assign res    = (ts_q == 8'd0) ? '0 : mem_rd;
  assign pot    = sat_add(acc_q, res);
  assign spike  = (pot >= ACC_W'(THRESH));
  assign mem_wd = spike ? pot - ACC_W'(THRESH) : pot;
  assign mem_we = (state_q == ST_FIRE);

  st_membrane_mem #(
    .DEPTH (DEPTH),
    .ACC_W (ACC_W),
    .AW    (ROW_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (row_q[ROW_W-1:0]),
    .wdata_i (mem_wd),
    .raddr_i (row_q[ROW_W-1:0]),
    .rdata_o (mem_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ACC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACC:  if (last_psum) state_d = ST_FIRE;
      ST_FIRE: state_d = ST_SEND;
      ST_SEND: if (out_hs) state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_ACC);
    out_valid = (state_q == ST_SEND);
  end

  always_comb begin
    acc_d  = acc_q;
    pcnt_d = pcnt_q;
    row_d  = row_q;
    ts_d   = ts_q;
    out_d  = out_q;
    done_d = 1'b0;
    err_d  = err_q;
    if (accept && !pkt_ok) err_d = 1'b1;
    if (take) begin
      acc_d  = sat_add(acc_q, psum_ext);
      pcnt_d = pcnt_q + 1'b1;
    end
    if (state_q == ST_FIRE) begin
      out_d  = {ST_ADDR, OUT_ADDR, TYPE_SPIKE,
                ts_q, row_q, 7'd0, spike};
      acc_d  = '0;
      pcnt_d = '0;
    end
    if (out_hs) begin
      if (last_row) begin
        row_d = 8'd0;
        if (last_ts) begin
          ts_d   = 8'd0;
          done_d = 1'b1;
        end else begin
          ts_d = ts_q + 8'd1;
        end
      end else begin
        row_d = row_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      pcnt_q <= '0;
      row_q  <= '0;
      ts_q   <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      pcnt_q <= pcnt_d;
      row_q  <= row_d;
      ts_q   <= ts_d;
      out_q  <= out_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign out_data = out_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
